// File: rtl/snn_axil_cfg_master.sv
// rtl/snn_axil_cfg_master.sv - AXI4-Lite initiator driven by a command/response stream (optional watchdog: SNN_AXIL_MASTER_TIMEOUT_EN)
module snn_axil_cfg_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    output logic                    err_timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WR_B  = 3'd2,
        RD_AR = 3'd3,
        RD_R  = 3'd4,
        RSP   = 3'd5
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;

    // Handshake qualifiers; all of them are gated by registered VALID/READY outputs
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire, cmd_fire;
    assign aw_fire  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_fire   = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_fire   = M_AXI_BREADY  & M_AXI_BVALID;
    assign ar_fire  = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_fire   = M_AXI_RREADY  & M_AXI_RVALID;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign cmd_fire = cmd_valid & cmd_ready;

    // Transaction sequencer with every output registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_write) begin
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR;
                        end else begin
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_AR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (aw_fire) begin
                        M_AXI_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        M_AXI_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (b_fire) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RD_AR: begin
                    if (ar_fire) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_R;
                    end
                end
                RD_R: begin
                    if (r_fire) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SNN_AXIL_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      wdog_state;
    logic [15:0] wdog_count;
    logic [15:0] wdog_next;
    logic        in_wait;

    // Cycles spent in the current wait state, including this one; restarts on every state entry
    always_comb begin
        in_wait = (state == WR) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
        if (state != wdog_state) begin
            wdog_next = 16'd1;
        end else if (wdog_count == 16'hFFFF) begin
            wdog_next = wdog_count;
        end else begin
            wdog_next = wdog_count + 16'd1;
        end
    end

    // Sticky watchdog flag; the transaction itself keeps waiting so VALID is never withdrawn
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_state  <= IDLE;
            wdog_count  <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            wdog_state <= state;
            if (in_wait) begin
                wdog_count <= wdog_next;
                if (wdog_next >= TIMEOUT_LIMIT) begin
                    err_timeout <= 1'b1;
                end
            end else begin
                wdog_count <= 16'd0;
            end
        end
    end
`else
    // No watchdog built; the parameter is only referenced to keep the interface uniform
    assign err_timeout = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_snn_axil_cfg_master.sv
// tb/tb_snn_axil_cfg_master.sv - scoreboard bench for snn_axil_cfg_master
module tb_snn_axil_cfg_master;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          err_timeout;

    always #5 clk = ~clk;

    snn_axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .err_timeout(err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic [1:0]    r;
    } rsp_t;
    rsp_t exp_q[$];

    // Slave behaviour knobs, set by the stimulus thread
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [DW-1:0] rdata_cfg = '0;

    // Expected AXI payload of the transaction in flight
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [3:0]    exp_wstrb;
    int            aw_hi = 0, w_hi = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // AXI slave model: READY/VALID after a programmable number of cycles
    initial begin
        int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
        awready = 0; wready = 0; arready = 0;
        bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin arready = 0; ar_cnt = 0; end
            if (bready) begin
                bvalid = (b_cnt >= b_delay);
                bresp  = bvalid ? bresp_cfg : 2'b00;
                b_cnt++;
            end else begin bvalid = 0; bresp = 0; b_cnt = 0; end
            if (rready) begin
                rvalid = (r_cnt >= r_delay);
                rdata  = rvalid ? rdata_cfg : '0;
                rresp  = rvalid ? rresp_cfg : 2'b00;
                r_cnt++;
            end else begin rvalid = 0; rdata = 0; rresp = 0; r_cnt = 0; end
        end
    end

    // Monitor: AXI payload at handshakes and response scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            if (awvalid && awready) check("awaddr", 64'(awaddr), 64'(exp_addr));
            if (wvalid && wready) begin
                check("wdata", 64'(wdata), 64'(exp_wdata));
                check("wstrb", 64'(wstrb), 64'(exp_wstrb));
            end
            if (arvalid && arready) check("araddr", 64'(araddr), 64'(exp_addr));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got rdata 0x%0h, expected no response", rsp_rdata);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_write", 64'(rsp_write), 64'(e.w));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.d));
                    check("rsp_resp", 64'(rsp_resp), 64'(e.r));
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input logic [DW-1:0] exp_d,
                            input logic [1:0] exp_r, input bit push);
        bit acc = 0;
        int cyc = 0;
        rsp_t e;
        exp_addr = a; exp_wdata = d; exp_wstrb = s;
        aw_hi = 0; w_hi = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            if (cmd_ready) acc = 1;
            @(posedge clk); #1;
            cyc++;
        end
        cmd_valid = 0;
        if (!acc) begin
            fail_now("cmd_accept");
        end else begin
            if (push) begin
                e.w = w; e.d = exp_d; e.r = exp_r;
                exp_q.push_back(e);
            end
            @(negedge clk);
            check("accept_to_valid", 64'({awvalid, wvalid, arvalid}), w ? 64'h6 : 64'h1);
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        bit ok = 0;
        while (!ok && cyc < 200) begin
            @(negedge clk);
            if (exp_q.size() == 0 && cmd_ready) ok = 1;
            cyc++;
        end
        if (!ok) fail_now(name);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic exp_err;
        int   cyc;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, err_timeout}), 64'h0);
        check("reset_data", 64'({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_write}), 64'h0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); @(negedge clk);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'h1);

        // Write with AWREADY delayed 3 cycles, WREADY immediate
        aw_delay = 3; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
        send_cmd(1, 16'h0004, 32'h0000_0001, 4'hF, 32'h0, 2'b00, 1);
        wait_drain("drain_write1");
        check("awvalid_cycles", 64'(aw_hi), 64'd4);
        check("wvalid_cycles", 64'(w_hi), 64'd1);

        // Read with RVALID two cycles after RREADY
        aw_delay = 0; ar_delay = 0; r_delay = 2; rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
        send_cmd(0, 16'h0008, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1);
        wait_drain("drain_read1");

        // Response stall: payload stable, no new command accepted
        rsp_ready = 0; r_delay = 0; rdata_cfg = 32'h1234_5678;
        send_cmd(0, 16'h0010, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
        if (!rsp_valid) fail_now("stall_rsp_valid");
        for (int i = 0; i < 5; i++) begin
            check("stall_payload", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp}), {29'h0, 1'b1, 1'b0, 32'h1234_5678, 2'b00});
            check("stall_cmd_ready", 64'(cmd_ready), 64'h0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1;
        // Next command: AW and W complete in different cycles
        w_delay = 2;
        send_cmd(1, 16'h0020, 32'hA5A5_5A5A, 4'h3, 32'h0, 2'b00, 1);
        wait_drain("drain_stall");
        check("wvalid_cycles_delayed", 64'(w_hi), 64'd3);
        check("awvalid_cycles_immediate", 64'(aw_hi), 64'd1);

        // Error responses pass through unchanged
        w_delay = 0; bresp_cfg = 2'b10;
        send_cmd(1, 16'h000C, 32'hFFFF_0000, 4'hC, 32'h0, 2'b10, 1);
        wait_drain("drain_slverr");
        rresp_cfg = 2'b11; rdata_cfg = 32'h0BAD_F00D; r_delay = 1;
        send_cmd(0, 16'h0014, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b11, 1);
        wait_drain("drain_decerr");
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;

        // Reset while waiting in WR_B
        b_delay = 1000;
        send_cmd(1, 16'h0030, 32'h0000_0055, 4'hF, 32'h0, 2'b00, 0);
        cyc = 0;
        while (!bready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bready) fail_now("reach_wr_b");
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("post_reset_handshakes", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'h0);
        @(negedge clk);
        check("post_reset_cmd_ready", 64'(cmd_ready), 64'h1);
        b_delay = 0;

        // Read stalled on ARREADY: watchdog when built, ARVALID never withdrawn
`ifdef SNN_AXIL_MASTER_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        ar_delay = 20; rdata_cfg = 32'hCAFE_F00D;
        send_cmd(0, 16'h0040, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1);
        repeat (7) @(negedge clk);
        check("err_before_limit", 64'({err_timeout, arvalid}), 64'h1);
        @(negedge clk);
        check("err_at_limit", 64'({err_timeout, arvalid}), {62'h0, exp_err, 1'b1});
        wait_drain("drain_timeout");
        check("err_sticky", 64'(err_timeout), 64'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
